// File: rtl/ack_queue_mc.sv
// Multi-channel acknowledgement queue: coalesces per-channel sequence reports and
// serialises one two-beat ack frame per pending channel onto AXI-Stream, round-robin.
module ack_queue_mc #(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned SEQ_W    = 32,
    parameter int unsigned DATA_W   = 512,
    parameter logic [15:0] ACK_TYPE = 16'hACC0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH*SEQ_W-1:0]   seq_in,
    input  logic [NUM_CH-1:0]         seq_valid,
    output logic [DATA_W-1:0]         tx_tdata,
    output logic [DATA_W/8-1:0]       tx_tkeep,
    output logic [63:0]               tx_tuser,
    output logic                      tx_tvalid,
    output logic                      tx_tlast,
    input  logic                      tx_tready,
    output logic [31:0]               ack_sent_cnt
);

    localparam int unsigned KEEP_W = DATA_W / 8;
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [KEEP_W-1:0] HDR_KEEP = KEEP_W'(4'hF);
    localparam logic [KEEP_W-1:0] SEQ_KEEP = KEEP_W'((64'd1 << (SEQ_W / 8)) - 64'd1);
    localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {IDLE, HDR, SEQ} state_e;

    state_e                 state_q, state_d;
    logic [NUM_CH-1:0]      pend_q, pend_d;
    logic [NUM_CH-1:0]      sent_v_q, sent_v_d;
    logic [SEQ_W-1:0]       seq_q [NUM_CH];
    logic [SEQ_W-1:0]       seq_d [NUM_CH];
    logic [SEQ_W-1:0]       last_sent_q [NUM_CH];
    logic [SEQ_W-1:0]       last_sent_d [NUM_CH];
    logic [CH_W-1:0]        last_grant_q, last_grant_d;
    logic [SEQ_W-1:0]       snap_q, snap_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic [KEEP_W-1:0]      keep_q, keep_d;
    logic [63:0]            user_q, user_d;
    logic                   valid_q, valid_d;
    logic                   last_q, last_d;
    logic [31:0]            cnt_q, cnt_d;

    logic                   grant_any;
    logic [CH_W-1:0]        grant_idx;
    logic                   grant_now;
    int unsigned            cand;

    // Serial-number comparison: a is strictly ahead of b within half the number space.
    function automatic logic newer(input logic [SEQ_W-1:0] a, input logic [SEQ_W-1:0] b);
        logic [SEQ_W-1:0] d;
        d = a - b;
        return (d != '0) && !d[SEQ_W-1];
    endfunction

    // Round-robin pick: first pending channel after last_grant, wrapping.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int i = 1; i <= int'(NUM_CH); i++) begin
            cand = 32'(last_grant_q) + 32'(i);
            if (cand >= NUM_CH) cand = cand - NUM_CH;
            if (!grant_any && pend_q[CH_W'(cand)]) begin
                grant_any = 1'b1;
                grant_idx = CH_W'(cand);
            end
        end
    end

    assign grant_now = (state_q == IDLE) && grant_any;

    // Per-channel bookkeeping; a report is judged against post-grant state so pend-set beats grant-clear.
    always_comb begin
        pend_d      = pend_q;
        sent_v_d    = sent_v_q;
        seq_d       = seq_q;
        last_sent_d = last_sent_q;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            if (grant_now && (grant_idx == CH_W'(c))) begin
                pend_d[c]      = 1'b0;
                sent_v_d[c]    = 1'b1;
                last_sent_d[c] = seq_q[c];
            end
            if (seq_valid[c]
                && (!sent_v_d[c] || newer(seq_in[c*SEQ_W +: SEQ_W], last_sent_d[c]))
                && (!pend_d[c]   || newer(seq_in[c*SEQ_W +: SEQ_W], seq_q[c]))) begin
                seq_d[c]  = seq_in[c*SEQ_W +: SEQ_W];
                pend_d[c] = 1'b1;
            end
        end
    end

    // Frame FSM; output registers are loaded with the values of the state being entered.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        snap_d       = snap_q;
        data_d       = data_q;
        keep_d       = keep_q;
        user_d       = user_q;
        valid_d      = valid_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    state_d      = HDR;
                    last_grant_d = grant_idx;
                    snap_d       = seq_q[grant_idx];
                    data_d       = DATA_W'(ACK_TYPE) | (DATA_W'(grant_idx) << 16);
                    keep_d       = HDR_KEEP;
                    user_d       = 64'(grant_idx);
                    valid_d      = 1'b1;
                    last_d       = 1'b0;
                end
            end
            HDR: begin
                if (tx_tready) begin
                    state_d = SEQ;
                    data_d  = DATA_W'(snap_q);
                    keep_d  = SEQ_KEEP;
                    last_d  = 1'b1;
                end
            end
            SEQ: begin
                if (tx_tready) begin
                    state_d = IDLE;
                    data_d  = '0;
                    keep_d  = '0;
                    user_d  = '0;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    cnt_d   = cnt_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pend_q       <= '0;
            sent_v_q     <= '0;
            last_grant_q <= LAST_CH;
            snap_q       <= '0;
            data_q       <= '0;
            keep_q       <= '0;
            user_q       <= '0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            cnt_q        <= '0;
            for (int c = 0; c < int'(NUM_CH); c++) begin
                seq_q[c]       <= '0;
                last_sent_q[c] <= '0;
            end
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            sent_v_q     <= sent_v_d;
            last_grant_q <= last_grant_d;
            snap_q       <= snap_d;
            data_q       <= data_d;
            keep_q       <= keep_d;
            user_q       <= user_d;
            valid_q      <= valid_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            seq_q        <= seq_d;
            last_sent_q  <= last_sent_d;
        end
    end

    assign tx_tdata     = data_q;
    assign tx_tkeep     = keep_q;
    assign tx_tuser     = user_q;
    assign tx_tvalid    = valid_q;
    assign tx_tlast     = last_q;
    assign ack_sent_cnt = cnt_q;

endmodule
